decoder_scan_nto2n: RTL

DECODER_SCAN_NTO2N -- requirements
Module: decoder_scan_nto2n

---
 rtl/decoder_pkg.sv | 25 ++
 rtl/dwell_timer.sv | 36 +++
 rtl/decoder_scan_nto2n.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning N-to-2^N decoder: mode encodings,
// parameter limits and a width helper for the dwell counter.
package decoder_pkg;

   // Operating modes as presented on the 2-bit mode input.
   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_DIRECT = 2'b01,
      MODE_SCAN   = 2'b10,
      MODE_PULSE  = 2'b11
   } mode_t;

   // Legal ranges for the decoder parameters.
   localparam int N_MIN     = 1;
   localparam int N_MAX     = 6;
   localparam int DWELL_MIN = 1;
   localparam int DWELL_MAX = 65535;

   // Counter width needed to count 0..dwell-1; a single bit is kept for
   // dwell=1 so the counter never collapses to a zero-width vector.
   function automatic int dwell_cw(input int dwell);
      return (dwell > 1) ? $clog2(dwell) : 1;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 and wraps, with synchronous clear and
// hold. tc flags the last cycle of a dwell period so the owner can step
// to the next line (or end a pulse) on the same edge the counter wraps.
module dwell_timer
   import decoder_pkg::*;
#(
   parameter int DWELL = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic hold,
   output logic tc
);

   localparam int            CW   = dwell_cw(DWELL);
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] count_reg;

   assign tc = (count_reg == LAST);

   // Clear has priority over hold; otherwise count up and wrap at terminal.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_reg <= '0;
      end else if (hold) begin
         count_reg <= count_reg;
      end else if (tc) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + CW'(1);
      end
   end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// N-to-2^N one-hot decoder with four modes: OFF, DIRECT (registered
// decode of code), SCAN (walks every line, DWELL cycles each, with a wrap
// strobe) and PULSE (one line for DWELL cycles per accepted start).
// All outputs are registered; ACTIVE_LOW inverts the one-hot lines,
// idle value included.
module decoder_scan_nto2n
   import decoder_pkg::*;
#(
   parameter int N          = 2,
   parameter int DWELL      = 4,
   parameter int ACTIVE_LOW = 0,
   localparam int OUT_W     = 2**N
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [N-1:0]     code,
   input  logic             start,
   output logic [OUT_W-1:0] out,
   output logic [N-1:0]     idx,
   output logic             busy,
   output logic             wrap
);

   // Per-line polarity mask: all ones flips active-high lines to active-low.
   localparam logic [OUT_W-1:0] POL_MASK =
      (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

   // Generic shift decode; valid for every legal N without width tables.
   function automatic logic [OUT_W-1:0] onehot(input logic [N-1:0] sel);
      return OUT_W'(1) << sel;
   endfunction

   mode_t            mode_in;
   mode_t            mode_reg;
   logic             mode_change;
   logic             scan_steady;
   logic             pulse_run;
   logic             tc;

   logic [OUT_W-1:0] out_reg;
   logic [N-1:0]     idx_reg;
   logic             busy_reg;
   logic             wrap_reg;

   logic [OUT_W-1:0] line_next;
   logic [OUT_W-1:0] out_next;
   logic [N-1:0]     idx_next;
   logic             busy_next;
   logic             wrap_next;
   logic             tmr_clr;
   logic             tmr_hold;

   assign mode_in     = mode_t'(mode);

   // mode_reg holds the last mode seen while enabled, so a difference marks
   // a mode entry (including the first mode after reset, since reset
   // parks mode_reg at OFF and OFF needs no entry action).
   assign mode_change = (mode_in != mode_reg);
   assign scan_steady = (mode_in == MODE_SCAN) && !mode_change;
   assign pulse_run   = (mode_in == MODE_PULSE) && !mode_change && busy_reg;

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .clr  (tmr_clr),
      .hold (tmr_hold),
      .tc   (tc)
   );

   // Next-state decode for every mode; defaults describe the idle state
   // with the dwell counter cleared.
   always_comb begin
      line_next = '0;
      idx_next  = '0;
      busy_next = 1'b0;
      wrap_next = 1'b0;
      tmr_clr   = 1'b1;
      tmr_hold  = 1'b0;

      if (!en) begin
         // Lines go idle but position, dwell count and busy are frozen so
         // the sequence picks up where it stopped once en returns.
         idx_next  = idx_reg;
         busy_next = busy_reg;
         tmr_clr   = 1'b0;
         tmr_hold  = 1'b1;
      end else begin
         case (mode_in)
            MODE_OFF: begin
               line_next = '0;
            end

            MODE_DIRECT: begin
               idx_next  = code;
               line_next = onehot(code);
            end

            MODE_SCAN: begin
               if (scan_steady) begin
                  tmr_clr = 1'b0;
                  if (tc) begin
                     // Last dwell cycle of this line: step on, and flag
                     // the return from the top line to line 0.
                     idx_next  = idx_reg + N'(1);
                     wrap_next = (idx_reg == N'(OUT_W - 1));
                  end else begin
                     idx_next  = idx_reg;
                  end
               end else begin
                  // Entry: start at line 0 with a fresh dwell count.
                  idx_next = '0;
               end
               line_next = onehot(idx_next);
            end

            MODE_PULSE: begin
               if (pulse_run) begin
                  // Pulse in flight; start is ignored, not queued.
                  tmr_clr = 1'b0;
                  if (!tc) begin
                     busy_next = 1'b1;
                     idx_next  = idx_reg;
                     line_next = onehot(idx_reg);
                  end
               end else if (start) begin
                  // Accept: capture code and light its line from the next
                  // cycle, counting DWELL cycles from a cleared counter.
                  busy_next = 1'b1;
                  idx_next  = code;
                  line_next = onehot(code);
               end
            end

            default: begin
               line_next = '0;
            end
         endcase
      end
   end

   // Apply output polarity bit by bit before registering.
   generate
      for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pol
         assign out_next[gi] = line_next[gi] ^ POL_MASK[gi];
      end
   endgenerate

   // Output and control registers; reset parks everything idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg <= MODE_OFF;
         out_reg  <= POL_MASK;
         idx_reg  <= '0;
         busy_reg <= 1'b0;
         wrap_reg <= 1'b0;
      end else begin
         if (en) begin
            mode_reg <= mode_in;
         end
         out_reg  <= out_next;
         idx_reg  <= idx_next;
         busy_reg <= busy_next;
         wrap_reg <= wrap_next;
      end
   end

   assign out  = out_reg;
   assign idx  = idx_reg;
   assign busy = busy_reg;
   assign wrap = wrap_reg;

endmodule
